fpnew_cast_rr_scheduler: RTL and testbench
==========================================

// Module: fpnew_cast_rr_scheduler
// PURPOSE
//  Shares one FP/int cast pipeline between NumReq requesters (e.g. SIMD lanes or issue ports).
//  Round-robin issue with grant lock until handshake, per-requester credit limit on in-flight ops.
//  Requester ID travels with the op through the pipeline; results are demuxed back by ID.
//  Sits between the requesters and the cast pipeline's input and output handshakes.
// PARAMETERS
//  NumReq         2       number of requesters, >=2
//  MaxOutstanding 4       max in-flight ops per requester, >=1
//  ReqType        logic   request payload type (operands, fmt, rnd_mode, tag, aux)
//  RspType        logic   result payload type returned by the pipeline
//  IdWidth        $clog2(NumReq)  derived localparam, not overridable
// PORTS
//  clk_i            in   1              clock
//  rst_ni           in   1              reset, asynchronous, active-low
//  flush_i          in   1              sync flush; the pipeline is flushed in the same cycle
//  req_valid_i      in   NumReq         request valid per requester
//  req_ready_o      out  NumReq         request accepted (issue handshake)
//  req_data_i       in   NumReq×ReqType request payloads
//  pipe_valid_o     out  1              issue valid to pipeline
//  pipe_ready_i     in   1              pipeline input ready
//  pipe_data_o      out  ReqType        payload of granted requester
//  pipe_id_o        out  IdWidth        granted requester ID (into pipeline aux)
//  pipe_out_valid_i in   1              pipeline result valid
//  pipe_out_ready_o out  1              result accepted
//  pipe_out_data_i  in   RspType        result payload
//  pipe_out_id_i    in   IdWidth        ID returned with the result
//  rsp_valid_o      out  NumReq         result valid per requester
//  rsp_ready_i      in   NumReq         requester result ready
//  rsp_data_o       out  RspType        result payload (broadcast)
//  busy_o           out  1              any op locked or in flight
// BEHAVIOUR
//  State: rr_ptr_q (IdWidth), lock_q (1), lock_id_q (IdWidth), cnt_q[NumReq] ($clog2(MaxOutstanding+1)).
//  Reset: rr_ptr_q=0, lock_q=0, lock_id_q=0, cnt_q=0. Outputs are then: pipe_valid_o=0,
//   req_ready_o=0, rsp_valid_o=0, busy_o=0; pipe_out_ready_o follows rsp_ready_i[pipe_out_id_i].
//  Eligible[k] = req_valid_i[k] & (cnt_q[k] < MaxOutstanding).
//  FSM ARB (lock_q=0): winner = first eligible at or after rr_ptr_q, wrapping; none -> pipe_valid_o=0.
//   pipe_valid_o=1, pipe_data_o/pipe_id_o = winner. Handshake -> rr_ptr_q=winner+1 (mod NumReq), stay ARB.
//   No handshake -> LOCKED with lock_id_q=winner.
//  FSM LOCKED: issue lock_id_q only, regardless of credit or of other valids; handshake -> ARB,
//   rr_ptr_q=lock_id_q+1. Requester must hold valid/data stable (AXI rule); dropping it is a protocol error.
//  req_ready_o[k] = pipe_ready_i & pipe_valid_o & (granted id == k); zero-latency, combinational.
//  Return: rsp_valid_o[k] = pipe_out_valid_i & (pipe_out_id_i==k); pipe_out_ready_o = rsp_ready_i[id].
//   Out-of-range id (>=NumReq): pipe_out_ready_o=1, result dropped, assertion fires.
//  Credit: cnt_q[k] +1 on issue handshake for k, -1 on return handshake for k.
//   Both in the same cycle: no change. Decrement at 0 or increment at max: assertion, saturate.
//  flush_i: next cycle lock_q=0, cnt_q=0. rr_ptr_q is kept. Issue/return handshakes in the flush cycle are void.
//  busy_o = lock_q | (|cnt_q) | pipe_valid_o.
//  Latency: 0 cycles added on issue and return paths. Fairness: eligible requester wins within NumReq grants.
// CONFIGURATION
//  FPNEW_CAST_SCHED_STATS_EN defined: adds output stat_issue_o [NumReq][31:0] (wrapping issue counters)
//   and stat_stall_o [31:0] (cycles pipe_valid_o & ~pipe_ready_i). Both reset to 0 and are not cleared by flush.
//  Not defined: ports absent, no counter flops; all other behaviour identical.
// STRUCTURE
//  fpnew_pkg: add typedef enum logic {SCHED_ARB, SCHED_LOCKED} sched_state_e.
//  Sub-module fpnew_rr_pick: combinational rotate, leading-one pick, rotate back
//   (in: eligible mask + ptr; out: winner id + any).
//  Flops use common_cells register macros with async reset.
// TESTING
//  Reset, all req_valid_i=1, pipe_ready_i=1, NumReq=4 -> grants 0,1,2,3,0 on consecutive cycles.
//  Grant req 2 with pipe_ready_i=0 for 3 cycles while req 0 is valid -> pipe_id_o stays 2, then rr_ptr_q=3.
//  MaxOutstanding=2, req 1 issues twice with no returns -> req 1 ineligible; one return (id=1) -> eligible next cycle.
//  Issue and return for req 0 in the same cycle with cnt_q[0]=1 -> cnt_q[0] stays 1.
//  pipe_out_id_i=3 with rsp_ready_i[3]=0 -> pipe_out_ready_o=0, only rsp_valid_o[3]=1.
//  flush_i while LOCKED with cnt_q={1,2,0,0} -> next cycle ARB, all counts 0, busy_o=0 when no req valid.

Source files
------------

// File: rtl/fpnew_cast_rr_scheduler_pkg.sv
// Shared types for the cast-pipeline round-robin scheduler.
package fpnew_cast_rr_scheduler_pkg;

    typedef enum logic {SCHED_ARB, SCHED_LOCKED} sched_state_e;

    localparam int unsigned StatWidth = 32;

endpackage

// File: rtl/fpnew_cast_rr_scheduler_pick.sv
// Round-robin picker: first set bit of mask_i at or after ptr_i, wrapping around.
module fpnew_cast_rr_scheduler_pick #(
    parameter int unsigned NumReq  = 2,
    parameter int unsigned IdWidth = $clog2(NumReq)
) (
    input  logic [NumReq-1:0]  mask_i,
    input  logic [IdWidth-1:0] ptr_i,
    output logic [IdWidth-1:0] id_o,
    output logic               any_o
);

    localparam logic [IdWidth:0] NumReqW = (IdWidth + 1)'(NumReq);

    logic [NumReq-1:0]  rot;
    logic [IdWidth-1:0] off;
    logic [IdWidth:0]   sum;

    always_comb begin
        // Rotate so ptr_i lands on bit 0, take the lowest set bit, rotate the index back.
        rot = NumReq'({mask_i, mask_i} >> ptr_i);
        off = '0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (rot[i]) off = IdWidth'(i);
        end
        any_o = |rot;
        sum   = {1'b0, ptr_i} + {1'b0, off};
        id_o  = (sum >= NumReqW) ? IdWidth'(sum - NumReqW) : sum[IdWidth-1:0];
    end

endmodule

// File: rtl/fpnew_cast_rr_scheduler.sv
// Round-robin issue scheduler with grant lock and per-requester credits for a shared cast pipeline.
// Optional statistics counters are enabled with `define FPNEW_CAST_SCHED_STATS_EN.
module fpnew_cast_rr_scheduler
    import fpnew_cast_rr_scheduler_pkg::*;
#(
    parameter int unsigned NumReq         = 2,
    parameter int unsigned MaxOutstanding = 4,
    parameter type         ReqType        = logic,
    parameter type         RspType        = logic,
    localparam int unsigned IdWidth       = $clog2(NumReq)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic [NumReq-1:0]    req_valid_i,
    output logic [NumReq-1:0]    req_ready_o,
    input  ReqType               req_data_i [NumReq],
    output logic                 pipe_valid_o,
    input  logic                 pipe_ready_i,
    output ReqType               pipe_data_o,
    output logic [IdWidth-1:0]   pipe_id_o,
    input  logic                 pipe_out_valid_i,
    output logic                 pipe_out_ready_o,
    input  RspType               pipe_out_data_i,
    input  logic [IdWidth-1:0]   pipe_out_id_i,
    output logic [NumReq-1:0]    rsp_valid_o,
    input  logic [NumReq-1:0]    rsp_ready_i,
    output RspType               rsp_data_o,
    output logic                 busy_o
`ifdef FPNEW_CAST_SCHED_STATS_EN
    ,
    output logic [StatWidth-1:0] stat_issue_o [NumReq],
    output logic [StatWidth-1:0] stat_stall_o
`endif
);

    localparam int unsigned          CntWidth = $clog2(MaxOutstanding + 1);
    localparam logic [CntWidth-1:0]  CntMax   = CntWidth'(MaxOutstanding);

    sched_state_e         state_q, state_d;
    logic [IdWidth-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IdWidth-1:0]   lock_id_q, lock_id_d;
    logic [CntWidth-1:0]  cnt_q [NumReq];
    logic [CntWidth-1:0]  cnt_d [NumReq];
    logic [NumReq-1:0]    eligible, inc_vec, dec_vec;
    logic [IdWidth-1:0]   win_id, grant_id;
    logic                 win_any, issue_hs, ret_hs, id_in_range, cnt_any;

    function automatic logic [IdWidth-1:0] next_id(input logic [IdWidth-1:0] id);
        return (32'(id) == NumReq - 1) ? '0 : id + IdWidth'(1);
    endfunction

    always_comb begin
        cnt_any = 1'b0;
        for (int k = 0; k < NumReq; k++) begin
            eligible[k] = req_valid_i[k] & (cnt_q[k] < CntMax);
            cnt_any     = cnt_any | (cnt_q[k] != '0);
        end
    end

    fpnew_cast_rr_scheduler_pick #(
        .NumReq  (NumReq),
        .IdWidth (IdWidth)
    ) i_pick (
        .mask_i (eligible),
        .ptr_i  (rr_ptr_q),
        .id_o   (win_id),
        .any_o  (win_any)
    );

    // Issue and return paths are purely combinational.
    always_comb begin
        grant_id     = win_id;
        pipe_valid_o = win_any;
        if (state_q == SCHED_LOCKED) begin
            grant_id     = lock_id_q;
            pipe_valid_o = req_valid_i[lock_id_q];
        end
        pipe_id_o             = grant_id;
        pipe_data_o           = req_data_i[grant_id];
        issue_hs              = pipe_valid_o & pipe_ready_i;
        req_ready_o           = '0;
        req_ready_o[grant_id] = issue_hs;

        id_in_range      = 32'(pipe_out_id_i) < NumReq;
        pipe_out_ready_o = id_in_range ? rsp_ready_i[pipe_out_id_i] : 1'b1;
        rsp_valid_o      = '0;
        if (id_in_range) rsp_valid_o[pipe_out_id_i] = pipe_out_valid_i;
        rsp_data_o       = pipe_out_data_i;
        ret_hs           = pipe_out_valid_i & pipe_out_ready_o & id_in_range;

        busy_o = (state_q == SCHED_LOCKED) | cnt_any | pipe_valid_o;
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        lock_id_d = lock_id_q;
        if (flush_i) begin
            state_d = SCHED_ARB;
        end else if (state_q == SCHED_ARB) begin
            if (issue_hs) begin
                rr_ptr_d = next_id(win_id);
            end else if (win_any) begin
                state_d   = SCHED_LOCKED;
                lock_id_d = win_id;
            end
        end else if (issue_hs) begin
            state_d  = SCHED_ARB;
            rr_ptr_d = next_id(lock_id_q);
        end

        // Simultaneous issue and return for one requester cancel out.
        for (int k = 0; k < NumReq; k++) begin
            inc_vec[k] = issue_hs & (grant_id == IdWidth'(k));
            dec_vec[k] = ret_hs & (pipe_out_id_i == IdWidth'(k));
            cnt_d[k]   = cnt_q[k];
            if (flush_i) begin
                cnt_d[k] = '0;
            end else if (inc_vec[k] && !dec_vec[k] && cnt_q[k] != CntMax) begin
                cnt_d[k] = cnt_q[k] + CntWidth'(1);
            end else if (dec_vec[k] && !inc_vec[k] && cnt_q[k] != '0) begin
                cnt_d[k] = cnt_q[k] - CntWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= SCHED_ARB;
            rr_ptr_q  <= '0;
            lock_id_q <= '0;
            for (int k = 0; k < NumReq; k++) cnt_q[k] <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            lock_id_q <= lock_id_d;
            for (int k = 0; k < NumReq; k++) cnt_q[k] <= cnt_d[k];
        end
    end

`ifdef FPNEW_CAST_SCHED_STATS_EN
    logic [StatWidth-1:0] stat_issue_q [NumReq];
    logic [StatWidth-1:0] stat_stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NumReq; k++) stat_issue_q[k] <= '0;
            stat_stall_q <= '0;
        end else begin
            for (int k = 0; k < NumReq; k++) begin
                if (inc_vec[k]) stat_issue_q[k] <= stat_issue_q[k] + StatWidth'(1);
            end
            if (pipe_valid_o && !pipe_ready_i) stat_stall_q <= stat_stall_q + StatWidth'(1);
        end
    end

    assign stat_issue_o = stat_issue_q;
    assign stat_stall_o = stat_stall_q;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (rst_ni && !flush_i) begin
            assert (!(pipe_out_valid_i && !id_in_range))
                else $error("result with out-of-range id %0d dropped", pipe_out_id_i);
            assert (!(state_q == SCHED_LOCKED && !req_valid_i[lock_id_q]))
                else $error("requester %0d dropped valid while locked", lock_id_q);
            for (int k = 0; k < NumReq; k++) begin
                assert (!(inc_vec[k] && !dec_vec[k] && cnt_q[k] == CntMax))
                    else $error("credit overflow on requester %0d", k);
                assert (!(dec_vec[k] && !inc_vec[k] && cnt_q[k] == '0))
                    else $error("credit underflow on requester %0d", k);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fpnew_cast_rr_scheduler.sv
// Directed bench for the cast-pipeline round-robin scheduler (NumReq=4, MaxOutstanding=2).
module tb_fpnew_cast_rr_scheduler;

    localparam int unsigned N = 4;

    logic           clk_i = 1'b0;
    logic           rst_ni, flush_i;
    logic [N-1:0]   req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
    logic [7:0]     req_data_i [N];
    logic           pipe_valid_o, pipe_ready_i;
    logic [7:0]     pipe_data_o;
    logic [1:0]     pipe_id_o, pipe_out_id_i;
    logic           pipe_out_valid_i, pipe_out_ready_o;
    logic [15:0]    pipe_out_data_i, rsp_data_o;
    logic           busy_o;

    int vectors     = 0;
    int miscompares = 0;
    int exp_t1 [5]  = '{0, 1, 2, 3, 0};

    always #5 clk_i = ~clk_i;

    fpnew_cast_rr_scheduler #(
        .NumReq         (N),
        .MaxOutstanding (2),
        .ReqType        (logic [7:0]),
        .RspType        (logic [15:0])
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .flush_i          (flush_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_data_i       (req_data_i),
        .pipe_valid_o     (pipe_valid_o),
        .pipe_ready_i     (pipe_ready_i),
        .pipe_data_o      (pipe_data_o),
        .pipe_id_o        (pipe_id_o),
        .pipe_out_valid_i (pipe_out_valid_i),
        .pipe_out_ready_o (pipe_out_ready_o),
        .pipe_out_data_i  (pipe_out_data_i),
        .pipe_out_id_i    (pipe_out_id_i),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_ready_i      (rsp_ready_i),
        .rsp_data_o       (rsp_data_o),
        .busy_o           (busy_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
            else begin
                miscompares++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst_ni           = 1'b0;
        flush_i          = 1'b0;
        req_valid_i      = '0;
        rsp_ready_i      = 4'b0100;
        pipe_ready_i     = 1'b0;
        pipe_out_valid_i = 1'b0;
        pipe_out_id_i    = 2'd2;
        pipe_out_data_i  = '0;
        for (int k = 0; k < N; k++) req_data_i[k] = 8'hA0 + 8'(k);

        // Reset values
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_pipe_valid", 32'(pipe_valid_o), 0);
        check("rst_req_ready", 32'(req_ready_o), 0);
        check("rst_rsp_valid", 32'(rsp_valid_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_out_ready_id2", 32'(pipe_out_ready_o), 1);
        pipe_out_id_i = 2'd1;
        #1;
        check("rst_out_ready_id1", 32'(pipe_out_ready_o), 0);
        @(negedge clk_i);

        // All requesters valid, pipeline always ready: 0,1,2,3,0
        rst_ni        = 1'b1;
        rsp_ready_i   = '1;
        pipe_ready_i  = 1'b1;
        req_valid_i   = '1;
        pipe_out_id_i = 2'd0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("rr_valid", 32'(pipe_valid_o), 1);
            check("rr_id", 32'(pipe_id_o), 32'(exp_t1[i]));
            check("rr_req_ready", 32'(req_ready_o), 32'(1) << exp_t1[i]);
            check("rr_data", 32'(pipe_data_o), 32'hA0 + 32'(exp_t1[i]));
            @(negedge clk_i);
        end

        // Credits now {0:2,1:1,2:1,3:1}: requester 0 is out of credit
        req_valid_i = 4'b0001;
        #1;
        check("credit_block_valid", 32'(pipe_valid_o), 0);
        check("credit_block_busy", 32'(busy_o), 1);
        @(negedge clk_i);

        pipe_out_valid_i = 1'b1;
        pipe_out_id_i    = 2'd0;
        pipe_out_data_i  = 16'hBEEF;
        #1;
        check("ret0_rsp_valid", 32'(rsp_valid_o), 32'b0001);
        check("ret0_out_ready", 32'(pipe_out_ready_o), 1);
        check("ret0_rsp_data", 32'(rsp_data_o), 32'hBEEF);
        check("ret0_same_cycle_valid", 32'(pipe_valid_o), 0);
        @(negedge clk_i);

        // cnt 1: issue and return together leave it at 1
        pipe_out_data_i = 16'h1234;
        #1;
        check("both_valid", 32'(pipe_valid_o), 1);
        check("both_id", 32'(pipe_id_o), 0);
        check("both_req_ready", 32'(req_ready_o), 32'b0001);
        @(negedge clk_i);

        pipe_out_valid_i = 1'b0;
        #1;
        check("after_both_valid", 32'(pipe_valid_o), 1);
        check("after_both_id", 32'(pipe_id_o), 0);
        @(negedge clk_i);
        #1;
        check("cnt_full_again", 32'(pipe_valid_o), 0);
        @(negedge clk_i);

        // Lock on requester 2 while the pipeline stalls for three cycles
        req_valid_i  = 4'b0101;
        pipe_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("lock_valid", 32'(pipe_valid_o), 1);
            check("lock_id", 32'(pipe_id_o), 2);
            check("lock_req_ready", 32'(req_ready_o), 0);
            check("lock_data", 32'(pipe_data_o), 32'hA2);
            @(negedge clk_i);
        end
        pipe_ready_i = 1'b1;
        #1;
        check("lock_release_id", 32'(pipe_id_o), 2);
        check("lock_release_ready", 32'(req_ready_o), 32'b0100);
        @(negedge clk_i);

        // Credits {2,1,2,1}, pointer at 3: lock on 3, then flush
        req_valid_i  = '1;
        pipe_ready_i = 1'b0;
        #1;
        check("post_lock_id", 32'(pipe_id_o), 3);
        @(negedge clk_i);
        flush_i          = 1'b1;
        pipe_out_valid_i = 1'b1;
        pipe_out_id_i    = 2'd1;
        #1;
        check("flush_cycle_id", 32'(pipe_id_o), 3);
        check("flush_cycle_busy", 32'(busy_o), 1);
        @(negedge clk_i);

        flush_i          = 1'b0;
        pipe_out_valid_i = 1'b0;
        req_valid_i      = '0;
        #1;
        check("post_flush_valid", 32'(pipe_valid_o), 0);
        check("post_flush_busy", 32'(busy_o), 0);
        @(negedge clk_i);

        // Pointer kept at 3, credits cleared so 0 is eligible right after
        req_valid_i  = '1;
        pipe_ready_i = 1'b1;
        #1;
        check("post_flush_first", 32'(pipe_id_o), 3);
        @(negedge clk_i);
        #1;
        check("post_flush_second", 32'(pipe_id_o), 0);
        @(negedge clk_i);

        // Return to requester 3 while it is not ready
        req_valid_i      = '0;
        pipe_out_valid_i = 1'b1;
        pipe_out_id_i    = 2'd3;
        rsp_ready_i      = 4'b0111;
        #1;
        check("ret3_out_ready", 32'(pipe_out_ready_o), 0);
        check("ret3_rsp_valid", 32'(rsp_valid_o), 32'b1000);
        check("ret3_busy", 32'(busy_o), 1);
        @(negedge clk_i);
        rsp_ready_i = '1;
        #1;
        check("ret3_accept", 32'(pipe_out_ready_o), 1);
        @(negedge clk_i);
        pipe_out_id_i = 2'd0;
        #1;
        check("ret0_final_valid", 32'(rsp_valid_o), 32'b0001);
        @(negedge clk_i);
        pipe_out_valid_i = 1'b0;
        #1;
        check("idle_busy", 32'(busy_o), 0);
        check("idle_rsp_valid", 32'(rsp_valid_o), 0);
        @(negedge clk_i);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
